// File: rtl/ac97_pkg.sv
// Shared types and constants for the AC97 codec command scheduler: FSM states,
// register addresses and the power-up init command table.
package ac97_pkg;

   typedef enum logic [1:0] {
      ST_INIT        = 2'd0,
      ST_RUN         = 2'd1,
      ST_REINIT_PEND = 2'd2
   } state_e;

   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] data;
   } cmd_t;

   localparam int INIT_LEN = 7;

   localparam logic [7:0] REG_MASTER_VOL  = 8'h02;
   localparam logic [7:0] REG_HP_VOL      = 8'h04;
   localparam logic [7:0] REG_PC_BEEP_VOL = 8'h0A;
   localparam logic [7:0] REG_PHONE_VOL   = 8'h0C;
   localparam logic [7:0] REG_LINE_IN_VOL = 8'h10;
   localparam logic [7:0] REG_PCM_OUT_VOL = 8'h18;
   localparam logic [7:0] REG_GEN_PURPOSE = 8'h20;
   localparam logic [7:0] REG_VENDOR_ID   = 8'hFC;

   localparam cmd_t [0:INIT_LEN-1] INIT_TABLE = {
      {REG_MASTER_VOL,  16'h0303},
      {REG_HP_VOL,      16'h0707},
      {REG_PCM_OUT_VOL, 16'h0000},
      {REG_GEN_PURPOSE, 16'h8000},
      {REG_PHONE_VOL,   16'h8000},
      {REG_PC_BEEP_VOL, 16'h8000},
      {REG_LINE_IN_VOL, 16'h0808}
   };

   // Entries past the end of the table read as a harmless vendor-ID access.
   function automatic cmd_t init_cmd(input logic [7:0] idx);
      cmd_t c;
      c = {REG_VENDOR_ID, 16'h0000};
      if (idx < 8'(INIT_LEN))
         c = INIT_TABLE[idx[2:0]];
      return c;
   endfunction

endpackage

// File: rtl/ac97_rr_arb.sv
// Two-way round-robin selector: a lone request always wins, a tie goes to the
// requester named by pointer.
module ac97_rr_arb (
   input  logic [1:0] req,
   input  logic       pointer,
   output logic [1:0] win
);

   for (genvar gi = 0; gi < 2; gi++) begin : g_win
      assign win[gi] = req[gi] && (!req[1-gi] || (pointer == 1'(gi)));
   end

endmodule

// File: rtl/ac97_cmd_sched.sv
// Per-frame AC97 slot 1/2 command scheduler: plays the init table after reset
// or reinit, then round-robins register writes from two requesters.
module ac97_cmd_sched #(
   parameter int         INIT_LEN  = ac97_pkg::INIT_LEN,
   parameter logic [7:0] IDLE_ADDR = 8'hFC
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        reinit,
   input  logic [1:0]  req,
   input  logic [7:0]  req_addr0,
   input  logic [7:0]  req_addr1,
   input  logic [15:0] req_data0,
   input  logic [15:0] req_data1,
   output logic [1:0]  grant,
   output logic [7:0]  cmd_addr,
   output logic [15:0] cmd_data,
   output logic        cmd_valid,
   output logic        init_done
);
   import ac97_pkg::*;

   localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

   state_e           r_state, w_state_next;
   logic [IDX_W-1:0] r_idx, w_idx_next, w_eff_idx;
   logic             r_ptr, w_ptr_next;
   logic [7:0]       r_cmd_addr, w_addr_next;
   logic [15:0]      r_cmd_data, w_data_next;
   logic             r_cmd_valid, w_valid_next;
   logic [1:0]       r_grant, w_grant_next;
   logic             r_init_done, w_done_next;
   logic [1:0]       w_win;
   logic             w_init_step, w_run_step, w_last;
   cmd_t             w_tbl;

   ac97_rr_arb u_arb (
      .req     (req),
      .pointer (r_ptr),
      .win     (w_win)
   );

   // A reinit coinciding with a frame behaves as an init step from entry 0.
   assign w_init_step = frame_start && (reinit || r_state != ST_RUN);
   assign w_run_step  = frame_start && !reinit && r_state == ST_RUN;
   assign w_eff_idx   = reinit ? '0 : r_idx;
   assign w_last      = (w_eff_idx == IDX_W'(INIT_LEN - 1));
   assign w_tbl       = init_cmd(8'(w_eff_idx));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_INIT;
         r_idx       <= '0;
         r_ptr       <= 1'b0;
         r_cmd_addr  <= IDLE_ADDR;
         r_cmd_data  <= '0;
         r_cmd_valid <= 1'b0;
         r_grant     <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_idx       <= w_idx_next;
         r_ptr       <= w_ptr_next;
         r_cmd_addr  <= w_addr_next;
         r_cmd_data  <= w_data_next;
         r_cmd_valid <= w_valid_next;
         r_grant     <= w_grant_next;
         r_init_done <= w_done_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      if (w_init_step) begin
         if (w_last) begin
            w_state_next = ST_RUN;
            w_idx_next   = '0;
         end else begin
            w_state_next = ST_INIT;
            w_idx_next   = w_eff_idx + IDX_W'(1);
         end
      end else if (reinit) begin
         w_state_next = ST_REINIT_PEND;
         w_idx_next   = '0;
      end
   end

   always_comb begin
      w_addr_next  = r_cmd_addr;
      w_data_next  = r_cmd_data;
      w_valid_next = r_cmd_valid;
      w_grant_next = '0;
      w_done_next  = r_init_done;
      w_ptr_next   = r_ptr;
      if (w_init_step) begin
         w_addr_next  = w_tbl.addr;
         w_data_next  = w_tbl.data;
         w_valid_next = 1'b1;
         w_done_next  = w_last;
      end else if (reinit) begin
         w_done_next = 1'b0;
      end else if (w_run_step) begin
         // The pointer flips to favour whoever was not just served.
         if (w_win[0]) begin
            w_addr_next  = req_addr0;
            w_data_next  = req_data0;
            w_valid_next = 1'b1;
            w_grant_next = 2'b01;
            w_ptr_next   = 1'b1;
         end else if (w_win[1]) begin
            w_addr_next  = req_addr1;
            w_data_next  = req_data1;
            w_valid_next = 1'b1;
            w_grant_next = 2'b10;
            w_ptr_next   = 1'b0;
         end else begin
            w_addr_next  = IDLE_ADDR;
            w_data_next  = '0;
            w_valid_next = 1'b0;
         end
      end
   end

   assign grant     = r_grant;
   assign cmd_addr  = r_cmd_addr;
   assign cmd_data  = r_cmd_data;
   assign cmd_valid = r_cmd_valid;
   assign init_done = r_init_done;

endmodule

// File: tb/tb_ac97_cmd_sched.sv
// Scoreboard bench for ac97_cmd_sched: stimulus queues hand-computed expected
// outputs per update edge, a negedge monitor pops and compares them.
module tb_ac97_cmd_sched;

   logic        clock = 1'b0;
   logic        reset, frame_start, reinit;
   logic [1:0]  req;
   logic [7:0]  req_addr0, req_addr1;
   logic [15:0] req_data0, req_data1;
   logic [1:0]  grant;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        cmd_valid, init_done;

   typedef struct {
      int          id;
      logic [7:0]  a;
      logic [15:0] d;
      logic        v;
      logic [1:0]  g;
      logic        dn;
   } exp_t;

   exp_t exp_q[$];
   int   n_run  = 0;
   int   n_fail = 0;
   int   n_id   = 0;
   logic seen   = 1'b0;
   logic mon_en = 1'b0;

   logic [7:0]  ta [7] = '{8'h02, 8'h04, 8'h18, 8'h20, 8'h0C, 8'h0A, 8'h10};
   logic [15:0] td [7] = '{16'h0303, 16'h0707, 16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h0808};

   ac97_cmd_sched dut (
      .clock       (clock),
      .reset       (reset),
      .frame_start (frame_start),
      .reinit      (reinit),
      .req         (req),
      .req_addr0   (req_addr0),
      .req_addr1   (req_addr1),
      .req_data0   (req_data0),
      .req_data1   (req_data1),
      .grant       (grant),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .cmd_valid   (cmd_valid),
      .init_done   (init_done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) seen <= frame_start | reinit | reset;

   // Monitor: outputs may only change on reset/frame/reinit edges.
   always @(negedge clock) begin
      exp_t e;
      if (seen) begin
         n_run++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: DUT update with no expected entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            if ({cmd_addr, cmd_data, cmd_valid, grant, init_done} !== {e.a, e.d, e.v, e.g, e.dn}) begin
               n_fail++;
               $display("FAIL txn%0d: got addr=%h data=%h valid=%b grant=%b done=%b, want addr=%h data=%h valid=%b grant=%b done=%b",
                        e.id, cmd_addr, cmd_data, cmd_valid, grant, init_done, e.a, e.d, e.v, e.g, e.dn);
            end else begin
               $display("[TB] txn%0d ok addr=%h data=%h valid=%b grant=%b done=%b",
                        e.id, cmd_addr, cmd_data, cmd_valid, grant, init_done);
            end
         end
      end else if (mon_en) begin
         n_run++;
         if (grant !== 2'b00) begin
            n_fail++;
            $display("FAIL grant_pulse: got grant=%b off a frame edge, want 00 at %0t", grant, $time);
         end
      end
   end

   task automatic ev(input logic fs, input logic ri, input logic rs, input logic [1:0] rq,
                     input logic [7:0] a, input logic [15:0] d, input logic v,
                     input logic [1:0] g, input logic dn);
      exp_t e;
      @(posedge clock);
      #2;
      frame_start = fs;
      reinit      = ri;
      reset       = rs;
      req         = rq;
      e.id = n_id; e.a = a; e.d = d; e.v = v; e.g = g; e.dn = dn;
      n_id++;
      exp_q.push_back(e);
   endtask

   task automatic quiet(input logic [1:0] rq);
      @(posedge clock);
      #2;
      frame_start = 1'b0;
      reinit      = 1'b0;
      reset       = 1'b0;
      req         = rq;
   endtask

   initial begin
      reset = 1'b0; frame_start = 1'b0; reinit = 1'b0; req = 2'b00;
      req_addr0 = 8'h26; req_data0 = 16'h1111;
      req_addr1 = 8'h2C; req_data1 = 16'h2222;

      // Reset values, then the init table with both requesters asking.
      ev(1'b0, 1'b0, 1'b1, 2'b11, 8'hFC, 16'h0000, 1'b0, 2'b00, 1'b0);
      quiet(2'b11);
      mon_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         ev(1'b1, 1'b0, 1'b0, 2'b11, ta[i], td[i], 1'b1, 2'b00, (i == 6));
         quiet(2'b11);
      end

      // Round-robin with both requests held.
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) ev(1'b1, 1'b0, 1'b0, 2'b11, 8'h26, 16'h1111, 1'b1, 2'b01, 1'b1);
         else            ev(1'b1, 1'b0, 1'b0, 2'b11, 8'h2C, 16'h2222, 1'b1, 2'b10, 1'b1);
         quiet(2'b11);
      end

      // Idle frame, then a withdrawn request.
      ev(1'b1, 1'b0, 1'b0, 2'b00, 8'hFC, 16'h0000, 1'b0, 2'b00, 1'b1);
      quiet(2'b01);
      quiet(2'b00);
      ev(1'b1, 1'b0, 1'b0, 2'b00, 8'hFC, 16'h0000, 1'b0, 2'b00, 1'b1);
      quiet(2'b00);

      // Lone request 1 leaves the pointer on 0, so the next tie goes to 0.
      ev(1'b1, 1'b0, 1'b0, 2'b10, 8'h2C, 16'h2222, 1'b1, 2'b10, 1'b1);
      quiet(2'b11);
      ev(1'b1, 1'b0, 1'b0, 2'b11, 8'h26, 16'h1111, 1'b1, 2'b01, 1'b1);
      quiet(2'b11);

      // Reinit alone: command held, init_done drops; then restart from entry 0.
      ev(1'b0, 1'b1, 1'b0, 2'b11, 8'h26, 16'h1111, 1'b1, 2'b00, 1'b0);
      quiet(2'b11);
      ev(1'b1, 1'b0, 1'b0, 2'b11, ta[0], td[0], 1'b1, 2'b00, 1'b0);
      quiet(2'b11);
      ev(1'b1, 1'b0, 1'b0, 2'b11, ta[1], td[1], 1'b1, 2'b00, 1'b0);
      quiet(2'b11);
      // Reinit coincident with a frame during INIT.
      ev(1'b1, 1'b1, 1'b0, 2'b11, ta[0], td[0], 1'b1, 2'b00, 1'b0);
      quiet(2'b11);
      for (int i = 1; i < 7; i++) begin
         ev(1'b1, 1'b0, 1'b0, 2'b11, ta[i], td[i], 1'b1, 2'b00, (i == 6));
         quiet(2'b11);
      end
      // Pointer survived reinit and favours requester 1.
      ev(1'b1, 1'b0, 1'b0, 2'b11, 8'h2C, 16'h2222, 1'b1, 2'b10, 1'b1);
      quiet(2'b11);

      // Reinit coincident with a frame in RUN.
      ev(1'b1, 1'b1, 1'b0, 2'b11, ta[0], td[0], 1'b1, 2'b00, 1'b0);
      quiet(2'b11);
      ev(1'b1, 1'b0, 1'b0, 2'b11, ta[1], td[1], 1'b1, 2'b00, 1'b0);
      quiet(2'b11);
      ev(1'b1, 1'b0, 1'b0, 2'b11, ta[2], td[2], 1'b1, 2'b00, 1'b0);
      quiet(2'b11);

      // Reset mid-sequence wins over a coincident frame and reinit.
      ev(1'b1, 1'b1, 1'b1, 2'b11, 8'hFC, 16'h0000, 1'b0, 2'b00, 1'b0);
      quiet(2'b11);
      for (int i = 0; i < 7; i++) begin
         ev(1'b1, 1'b0, 1'b0, 2'b11, ta[i], td[i], 1'b1, 2'b00, (i == 6));
         quiet(2'b11);
      end
      // Pointer back to favouring requester 0 after reset.
      ev(1'b1, 1'b0, 1'b0, 2'b11, 8'h26, 16'h1111, 1'b1, 2'b01, 1'b1);
      quiet(2'b00);
      quiet(2'b00);
      quiet(2'b00);

      n_run++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d unconsumed entries, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
